csr_trap_ctrl: RTL and testbench

CSR_TRAP_CTRL -- requirements
Module: csr_trap_ctrl

---
 rtl/csr_pkg.sv | 36 +++
 rtl/csr_tvec_calc.sv | 29 ++
 rtl/csr_trap_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_csr_trap_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// csr_pkg: CSR operation encoding, controller state encoding, machine-mode CSR
// addresses and mstatus bit positions shared by the trap controller.
package csr_pkg;

    // Operation presented to the CSR file; CsrOpNone is the idle/read encoding.
    typedef enum logic [1:0] {
        CsrOpNone = 2'b00,
        CsrOpRw   = 2'b01,
        CsrOpRs   = 2'b10,
        CsrOpRc   = 2'b11
    } csrop_t;

    // Controller states kept as plain constants for compatibility with older tooling.
    typedef logic [3:0] ctrl_state_t;
    localparam ctrl_state_t StIdle     = 4'd0;
    localparam ctrl_state_t StWrEpc    = 4'd1;
    localparam ctrl_state_t StWrCause  = 4'd2;
    localparam ctrl_state_t StWrTval   = 4'd3;
    localparam ctrl_state_t StRdStatus = 4'd4;
    localparam ctrl_state_t StWrStatus = 4'd5;
    localparam ctrl_state_t StRdTvec   = 4'd6;
    localparam ctrl_state_t StRdEpc    = 4'd7;
    localparam ctrl_state_t StDone     = 4'd8;

    localparam logic [11:0] CsrAddrMstatus = 12'h300;
    localparam logic [11:0] CsrAddrMtvec   = 12'h305;
    localparam logic [11:0] CsrAddrMepc    = 12'h341;
    localparam logic [11:0] CsrAddrMcause  = 12'h342;
    localparam logic [11:0] CsrAddrMtval   = 12'h343;

    localparam int unsigned MstatusMie   = 3;
    localparam int unsigned MstatusMpie  = 7;
    localparam int unsigned MstatusMppLo = 11;
    localparam int unsigned MstatusMppHi = 12;

endpackage

// File: rtl/csr_tvec_calc.sv
// csr_tvec_calc: combinational trap-vector target from mtvec and mcause.
// Vectored mode only applies to interrupts; reserved modes fall back to direct.
module csr_tvec_calc #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] tvec_i,
    input  logic [DATA_WIDTH-1:0] cause_i,
    output logic [DATA_WIDTH-1:0] target_o
);

    logic [DATA_WIDTH-1:0] base;
    logic [DATA_WIDTH-1:0] offset;
    logic                  unused_cause_msb;

    // Cause bit just below the interrupt flag is shifted out by the *4 anyway.
    assign unused_cause_msb = cause_i[DATA_WIDTH-2];

    // Select direct base or base plus 4*cause for vectored interrupts.
    always_comb begin
        base   = {tvec_i[DATA_WIDTH-1:2], 2'b00};
        offset = {cause_i[DATA_WIDTH-3:0], 2'b00};
        if (tvec_i[1:0] == 2'b01 && cause_i[DATA_WIDTH-1]) begin
            target_o = base + offset;
        end else begin
            target_o = base;
        end
    end

endmodule

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: sequences machine-mode trap entry and mret through a single
// CSR file port, and arbitrates that port with instruction CSR accesses.
// Build option: define CSR_TRAP_TVAL_EN to include the mtval write on trap entry.
module csr_trap_ctrl
    import csr_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  trap_req_in,
    input  logic [DATA_WIDTH-1:0] trap_pc_in,
    input  logic [DATA_WIDTH-1:0] trap_cause_in,
    input  logic [DATA_WIDTH-1:0] trap_val_in,
    input  logic                  mret_req_in,
    input  logic                  ins_req_in,
    input  logic [ADDR_WIDTH-1:0] ins_addr_in,
    input  csrop_t                ins_op_in,
    input  logic [DATA_WIDTH-1:0] ins_wdata_in,
    output logic                  ins_gnt_out,
    output logic [ADDR_WIDTH-1:0] csr_addr_out,
    output logic                  csr_wr_en_out,
    output csrop_t                csr_op_out,
    output logic [DATA_WIDTH-1:0] csr_wdata_out,
    input  logic [DATA_WIDTH-1:0] csr_rd_data_in,
    output logic                  trap_ack_out,
    output logic                  redirect_valid_out,
    output logic [DATA_WIDTH-1:0] redirect_pc_out,
    output logic                  busy_out
);

    ctrl_state_t           state_q, state_d;
    logic                  mret_q, mret_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] cause_q, cause_d;
    logic [DATA_WIDTH-1:0] status_q, status_d;
    logic [DATA_WIDTH-1:0] redirect_q, redirect_d;
    logic [DATA_WIDTH-1:0] status_wr;
    logic [DATA_WIDTH-1:0] tvec_target;

`ifdef CSR_TRAP_TVAL_EN
    logic [DATA_WIDTH-1:0] val_q, val_d;
`else
    logic                  unused_trap_val;
    assign unused_trap_val = ^trap_val_in;
`endif

    csr_tvec_calc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_tvec_calc (
        .tvec_i  (csr_rd_data_in),
        .cause_i (cause_q),
        .target_o(tvec_target)
    );

    assign busy_out = (state_q != StIdle);

    // Updated mstatus: stack MIE on trap, restore it on mret; MPP always forced to M.
    always_comb begin
        status_wr = status_q;
        if (mret_q) begin
            status_wr[MstatusMie]  = status_q[MstatusMpie];
            status_wr[MstatusMpie] = 1'b1;
        end else begin
            status_wr[MstatusMpie] = status_q[MstatusMie];
            status_wr[MstatusMie]  = 1'b0;
        end
        status_wr[MstatusMppHi:MstatusMppLo] = 2'b11;
    end

    // Arbitration, sequencing, latch updates and CSR port drive.
    always_comb begin
        state_d    = state_q;
        mret_d     = mret_q;
        pc_d       = pc_q;
        cause_d    = cause_q;
        status_d   = status_q;
        redirect_d = redirect_q;
`ifdef CSR_TRAP_TVAL_EN
        val_d      = val_q;
`endif
        ins_gnt_out        = 1'b0;
        csr_addr_out       = '0;
        csr_wr_en_out      = 1'b0;
        csr_op_out         = CsrOpNone;
        csr_wdata_out      = '0;
        trap_ack_out       = 1'b0;
        redirect_valid_out = 1'b0;
        redirect_pc_out    = '0;
        unique case (state_q)
            StIdle: begin
                if (trap_req_in) begin
                    state_d = StWrEpc;
                    mret_d  = 1'b0;
                    pc_d    = trap_pc_in;
                    cause_d = trap_cause_in;
`ifdef CSR_TRAP_TVAL_EN
                    val_d   = trap_val_in;
`endif
                end else if (mret_req_in) begin
                    state_d = StRdStatus;
                    mret_d  = 1'b1;
                end else if (ins_req_in) begin
                    ins_gnt_out   = 1'b1;
                    csr_addr_out  = ins_addr_in;
                    csr_wr_en_out = 1'b1;
                    csr_op_out    = ins_op_in;
                    csr_wdata_out = ins_wdata_in;
                end
            end
            StWrEpc: begin
                csr_addr_out  = ADDR_WIDTH'(CsrAddrMepc);
                csr_wr_en_out = 1'b1;
                csr_op_out    = CsrOpRw;
                csr_wdata_out = pc_q;
                state_d       = StWrCause;
            end
            StWrCause: begin
                csr_addr_out  = ADDR_WIDTH'(CsrAddrMcause);
                csr_wr_en_out = 1'b1;
                csr_op_out    = CsrOpRw;
                csr_wdata_out = cause_q;
`ifdef CSR_TRAP_TVAL_EN
                state_d       = StWrTval;
`else
                state_d       = StRdStatus;
`endif
            end
`ifdef CSR_TRAP_TVAL_EN
            StWrTval: begin
                csr_addr_out  = ADDR_WIDTH'(CsrAddrMtval);
                csr_wr_en_out = 1'b1;
                csr_op_out    = CsrOpRw;
                csr_wdata_out = val_q;
                state_d       = StRdStatus;
            end
`endif
            StRdStatus: begin
                csr_addr_out = ADDR_WIDTH'(CsrAddrMstatus);
                status_d     = csr_rd_data_in;
                state_d      = StWrStatus;
            end
            StWrStatus: begin
                csr_addr_out  = ADDR_WIDTH'(CsrAddrMstatus);
                csr_wr_en_out = 1'b1;
                csr_op_out    = CsrOpRw;
                csr_wdata_out = status_wr;
                state_d       = mret_q ? StRdEpc : StRdTvec;
            end
            StRdTvec: begin
                csr_addr_out = ADDR_WIDTH'(CsrAddrMtvec);
                redirect_d   = tvec_target;
                state_d      = StDone;
            end
            StRdEpc: begin
                csr_addr_out = ADDR_WIDTH'(CsrAddrMepc);
                redirect_d   = {csr_rd_data_in[DATA_WIDTH-1:2], 2'b00};
                state_d      = StDone;
            end
            StDone: begin
                trap_ack_out       = 1'b1;
                redirect_valid_out = 1'b1;
                redirect_pc_out    = redirect_q;
                state_d            = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and latch registers; reset aborts any sequence in flight.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= StIdle;
            mret_q     <= 1'b0;
            pc_q       <= '0;
            cause_q    <= '0;
            status_q   <= '0;
            redirect_q <= '0;
`ifdef CSR_TRAP_TVAL_EN
            val_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            mret_q     <= mret_d;
            pc_q       <= pc_d;
            cause_q    <= cause_d;
            status_q   <= status_d;
            redirect_q <= redirect_d;
`ifdef CSR_TRAP_TVAL_EN
            val_q      <= val_d;
`endif
        end
    end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// tb_csr_trap_ctrl: directed and randomized checks of csr_trap_ctrl against a
// behavioural CSR file and rule-level expectations. Honours CSR_TRAP_TVAL_EN.
module tb_csr_trap_ctrl;
    import csr_pkg::*;

`ifdef CSR_TRAP_TVAL_EN
    localparam int TrapLat = 7;
    localparam bit TvalEn  = 1'b1;
`else
    localparam int TrapLat = 6;
    localparam bit TvalEn  = 1'b0;
`endif
    localparam int MretLat = 4;
    localparam int MaxWait = 30;

    logic        clk    = 1'b0;
    logic        arst_n = 1'b0;
    logic        trap_req_in = 1'b0;
    logic [31:0] trap_pc_in = '0, trap_cause_in = '0, trap_val_in = '0;
    logic        mret_req_in = 1'b0;
    logic        ins_req_in = 1'b0;
    logic [11:0] ins_addr_in = '0;
    csrop_t      ins_op_in = CsrOpNone;
    logic [31:0] ins_wdata_in = '0;
    logic        ins_gnt_out, csr_wr_en_out, trap_ack_out, redirect_valid_out, busy_out;
    logic [11:0] csr_addr_out;
    csrop_t      csr_op_out;
    logic [31:0] csr_wdata_out, csr_rd_data_in, redirect_pc_out;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    csr_trap_ctrl #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(12)
    ) dut (
        .clk               (clk),
        .arst_n            (arst_n),
        .trap_req_in       (trap_req_in),
        .trap_pc_in        (trap_pc_in),
        .trap_cause_in     (trap_cause_in),
        .trap_val_in       (trap_val_in),
        .mret_req_in       (mret_req_in),
        .ins_req_in        (ins_req_in),
        .ins_addr_in       (ins_addr_in),
        .ins_op_in         (ins_op_in),
        .ins_wdata_in      (ins_wdata_in),
        .ins_gnt_out       (ins_gnt_out),
        .csr_addr_out      (csr_addr_out),
        .csr_wr_en_out     (csr_wr_en_out),
        .csr_op_out        (csr_op_out),
        .csr_wdata_out     (csr_wdata_out),
        .csr_rd_data_in    (csr_rd_data_in),
        .trap_ack_out      (trap_ack_out),
        .redirect_valid_out(redirect_valid_out),
        .redirect_pc_out   (redirect_pc_out),
        .busy_out          (busy_out)
    );

    // Behavioural CSR file: combinational read, write on the clock edge.
    logic [31:0] csr_mem [4096];
    logic        pre_we = 1'b0;
    logic [11:0] pre_addr = '0;
    logic [31:0] pre_data = '0;
    assign csr_rd_data_in = csr_mem[csr_addr_out];

    always @(posedge clk) begin
        if (pre_we) begin
            csr_mem[pre_addr] <= pre_data;
        end else if (csr_wr_en_out) begin
            case (csr_op_out)
                CsrOpRw: csr_mem[csr_addr_out] <= csr_wdata_out;
                CsrOpRs: csr_mem[csr_addr_out] <= csr_mem[csr_addr_out] | csr_wdata_out;
                CsrOpRc: csr_mem[csr_addr_out] <= csr_mem[csr_addr_out] & ~csr_wdata_out;
                default: ;
            endcase
        end
    end

    // Count ack pulses and any cycle where ack and redirect_valid disagree.
    int ack_cnt  = 0;
    int pair_err = 0;
    always @(negedge clk) begin
        if (trap_ack_out === 1'b1) ack_cnt <= ack_cnt + 1;
        if (trap_ack_out !== redirect_valid_out) pair_err <= pair_err + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached (asserts=%0d fails=%0d)", n_assert, n_fail);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected redirect from the mtvec rules, written as plain arithmetic.
    function automatic logic [31:0] m_redirect(input logic [31:0] tvec, input logic [31:0] cause);
        logic [31:0] base;
        base = tvec - (tvec % 32'd4);
        if ((tvec % 32'd4) == 32'd1 && cause >= 32'h8000_0000)
            return base + (cause - 32'h8000_0000) * 32'd4;
        return base;
    endfunction

    function automatic logic [31:0] m_status_trap(input logic [31:0] s);
        logic [31:0] r;
        r = (s & ~32'h0000_1888) | 32'h0000_1800;
        if (s[3]) r = r | 32'h0000_0080;
        return r;
    endfunction

    function automatic logic [31:0] m_status_mret(input logic [31:0] s);
        logic [31:0] r;
        r = (s & ~32'h0000_1888) | 32'h0000_1880;
        if (s[7]) r = r | 32'h0000_0008;
        return r;
    endfunction

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    // Wait for the ack pulse; cyc = edges until ack, -1 if it never came.
    task automatic wait_ack(output int cyc, output logic [31:0] rpc, output int viol);
        cyc = -1; rpc = '0; viol = 0;
        for (int i = 1; i <= MaxWait; i++) begin
            @(posedge clk); #1;
            if (ins_gnt_out) viol++;
            if (trap_ack_out) begin
                cyc = i;
                rpc = redirect_pc_out;
                break;
            end
        end
    endtask

    task automatic do_trap(input logic [31:0] pc, input logic [31:0] cause, input logic [31:0] val,
                           output int cyc, output logic [31:0] rpc, output int viol);
        trap_pc_in = pc; trap_cause_in = cause; trap_val_in = val; trap_req_in = 1'b1;
        wait_ack(cyc, rpc, viol);
        trap_req_in = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_mret(output int cyc, output logic [31:0] rpc, output int viol);
        mret_req_in = 1'b1;
        wait_ack(cyc, rpc, viol);
        mret_req_in = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int          cyc, viol, ack0, sel;
        logic [31:0] rpc, tv, cs, pc, vl, st, ep, old, wd, exp_v;
        logic [11:0] ad;
        csrop_t      op;

        // Reset state
        #2;
        chk("rst_busy", 32'(busy_out), 32'd0);
        chk("rst_ack", 32'(trap_ack_out), 32'd0);
        chk("rst_redirect_valid", 32'(redirect_valid_out), 32'd0);
        chk("rst_wr_en", 32'(csr_wr_en_out), 32'd0);
        chk("rst_redirect_pc", redirect_pc_out, 32'd0);
        #10 arst_n = 1'b1;
        @(posedge clk); #1;

        // Synchronous trap into direct mtvec
        preload(CsrAddrMtvec, 32'h0000_1000);
        preload(CsrAddrMstatus, 32'h0000_0008);
        preload(CsrAddrMtval, 32'h1234_5678);
        ack0 = ack_cnt;
        do_trap(32'h80, 32'h2, 32'hDEAD, cyc, rpc, viol);
        chk("trap_latency", 32'(cyc), 32'(TrapLat));
        chk("trap_redirect", rpc, 32'h0000_1000);
        chk("trap_mepc", csr_mem[CsrAddrMepc], 32'h80);
        chk("trap_mcause", csr_mem[CsrAddrMcause], 32'h2);
        exp_v = TvalEn ? 32'hDEAD : 32'h1234_5678;
        chk("trap_mtval", csr_mem[CsrAddrMtval], exp_v);
        chk("trap_mstatus", csr_mem[CsrAddrMstatus], 32'h0000_1880);
        chk("trap_single_ack", 32'(ack_cnt - ack0), 32'd1);
        chk("trap_no_gnt_busy", 32'(viol), 32'd0);
        chk("trap_idle_after", 32'(busy_out), 32'd0);

        // Vectored interrupt
        preload(CsrAddrMtvec, 32'h0000_1001);
        do_trap(32'h400, 32'h8000_0007, 32'h55, cyc, rpc, viol);
        chk("vec_redirect", rpc, 32'h0000_101C);

        // mret
        preload(CsrAddrMstatus, 32'h0000_0080);
        preload(CsrAddrMepc, 32'h0000_0207);
        do_mret(cyc, rpc, viol);
        chk("mret_latency", 32'(cyc), 32'(MretLat));
        chk("mret_redirect", rpc, 32'h0000_0204);
        chk("mret_mstatus", csr_mem[CsrAddrMstatus], 32'h0000_1888);

        // Collision: trap, then mret, then the instruction access
        preload(CsrAddrMtvec, 32'h0000_2000);
        preload(CsrAddrMstatus, 32'h0000_0008);
        preload(12'h340, 32'h0);
        trap_pc_in = 32'h3006; trap_cause_in = 32'h5; trap_val_in = 32'h9;
        ins_addr_in = 12'h340; ins_op_in = CsrOpRw; ins_wdata_in = 32'hCAFE_F00D;
        trap_req_in = 1'b1; mret_req_in = 1'b1; ins_req_in = 1'b1;
        #1;
        chk("col_gnt_at_rise", 32'(ins_gnt_out), 32'd0);
        wait_ack(cyc, rpc, viol);
        trap_req_in = 1'b0;
        chk("col_trap_first", rpc, 32'h0000_2000);
        chk("col_trap_no_gnt", 32'(viol), 32'd0);
        wait_ack(cyc, rpc, viol);
        mret_req_in = 1'b0;
        chk("col_mret_second", rpc, 32'h0000_3004);
        chk("col_mret_no_gnt", 32'(viol), 32'd0);
        @(posedge clk); #1;
        chk("col_idle", 32'(busy_out), 32'd0);
        chk("col_gnt", 32'(ins_gnt_out), 32'd1);
        chk("col_gnt_wr_en", 32'(csr_wr_en_out), 32'd1);
        chk("col_gnt_addr", 32'(csr_addr_out), 32'h340);
        chk("col_gnt_wdata", csr_wdata_out, 32'hCAFE_F00D);
        @(posedge clk); #1;
        ins_req_in = 1'b0;
        chk("col_ins_write", csr_mem[12'h340], 32'hCAFE_F00D);
        chk("col_mstatus", csr_mem[CsrAddrMstatus], 32'h0000_1888);

        // Reset while in WR_STATUS, then the held trap runs to completion
        preload(CsrAddrMtvec, 32'h0000_4000);
        preload(CsrAddrMstatus, 32'h0000_0008);
        ack0 = ack_cnt;
        trap_pc_in = 32'h500; trap_cause_in = 32'h3; trap_val_in = 32'h77;
        trap_req_in = 1'b1;
        repeat (TrapLat - 2) @(posedge clk);
        #1 arst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy_out), 32'd0);
        chk("arst_ack", 32'(trap_ack_out), 32'd0);
        chk("arst_valid", 32'(redirect_valid_out), 32'd0);
        chk("arst_wr_en", 32'(csr_wr_en_out), 32'd0);
        chk("arst_addr", 32'(csr_addr_out), 32'd0);
        chk("arst_op", 32'(csr_op_out), 32'd0);
        chk("arst_wdata", csr_wdata_out, 32'd0);
        chk("arst_redirect_pc", redirect_pc_out, 32'd0);
        chk("arst_gnt", 32'(ins_gnt_out), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("arst_no_ack", 32'(ack_cnt - ack0), 32'd0);
        chk("arst_mstatus_untouched", csr_mem[CsrAddrMstatus], 32'h0000_0008);
        arst_n = 1'b1;
        wait_ack(cyc, rpc, viol);
        trap_req_in = 1'b0;
        @(posedge clk); #1;
        chk("arst_retry_latency", 32'(cyc), 32'(TrapLat));
        chk("arst_retry_redirect", rpc, 32'h0000_4000);
        chk("arst_retry_mstatus", csr_mem[CsrAddrMstatus], 32'h0000_1880);
        chk("arst_retry_one_ack", 32'(ack_cnt - ack0), 32'd1);

        // Randomized traps, mrets and instruction accesses
        for (int it = 0; it < 16; it++) begin
            sel = $urandom_range(0, 2);
            if (sel == 0) begin
                tv = $urandom; cs = $urandom; pc = $urandom; vl = $urandom; st = $urandom;
                old = $urandom;
                preload(CsrAddrMtvec, tv);
                preload(CsrAddrMstatus, st);
                preload(CsrAddrMtval, old);
                do_trap(pc, cs, vl, cyc, rpc, viol);
                chk("rnd_trap_latency", 32'(cyc), 32'(TrapLat));
                chk("rnd_trap_redirect", rpc, m_redirect(tv, cs));
                chk("rnd_trap_mepc", csr_mem[CsrAddrMepc], pc);
                chk("rnd_trap_mcause", csr_mem[CsrAddrMcause], cs);
                exp_v = TvalEn ? vl : old;
                chk("rnd_trap_mtval", csr_mem[CsrAddrMtval], exp_v);
                chk("rnd_trap_mstatus", csr_mem[CsrAddrMstatus], m_status_trap(st));
            end else if (sel == 1) begin
                st = $urandom; ep = $urandom;
                preload(CsrAddrMstatus, st);
                preload(CsrAddrMepc, ep);
                do_mret(cyc, rpc, viol);
                chk("rnd_mret_latency", 32'(cyc), 32'(MretLat));
                chk("rnd_mret_redirect", rpc, ep - (ep % 32'd4));
                chk("rnd_mret_mstatus", csr_mem[CsrAddrMstatus], m_status_mret(st));
            end else begin
                ad = 12'h340 + 12'($urandom_range(0, 3));
                old = $urandom; wd = $urandom;
                op = csrop_t'($urandom_range(1, 3));
                preload(ad, old);
                ins_addr_in = ad; ins_op_in = op; ins_wdata_in = wd; ins_req_in = 1'b1;
                #1;
                chk("rnd_ins_gnt", 32'(ins_gnt_out), 32'd1);
                @(posedge clk); #1;
                ins_req_in = 1'b0;
                if (op == CsrOpRw) exp_v = wd;
                else if (op == CsrOpRs) exp_v = old | wd;
                else exp_v = old & ~wd;
                chk("rnd_ins_result", csr_mem[ad], exp_v);
            end
        end

        chk("ack_valid_together", 32'(pair_err), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
